// File: rtl/mmo_game_regs.sv
// mmo_game_regs: memory-mapped game peripheral behind the HPS bridge.
// Provides an ID word, control/status, a button-event FIFO, a free-running
// tick prescaler/counter, synchronized button state and eight scratch words.
// Reads have a fixed latency of one cycle. All state is clocked by clk_clk.
module mmo_game_regs #(
    parameter int unsigned FIFO_DEPTH = 16,
    parameter logic [31:0] ID_VALUE   = 32'h47414D45
) (
    input  logic        clk_clk,
    input  logic        reset_reset,
    input  logic [4:0]  mmo_address,
    input  logic [31:0] mmo_writedata,
    input  logic [3:0]  mmo_byteenable,
    input  logic        mmo_read,
    input  logic        mmo_write,
    output logic [31:0] mmo_readdata,
    input  logic [4:0]  btn_in,
    output logic        irq
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

    localparam logic [4:0] ADDR_ID       = 5'd0;
    localparam logic [4:0] ADDR_CTRL     = 5'd1;
    localparam logic [4:0] ADDR_STATUS   = 5'd2;
    localparam logic [4:0] ADDR_EVENT    = 5'd3;
    localparam logic [4:0] ADDR_TICK_DIV = 5'd4;
    localparam logic [4:0] ADDR_TICK_CNT = 5'd5;
    localparam logic [4:0] ADDR_BTN_NOW  = 5'd6;

    // Replace only the byte lanes that are enabled.
    function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                                input logic [31:0] new_word,
                                                input logic [3:0]  lanes);
        logic [31:0] result;
        result = old_word;
        for (int i = 0; i < 4; i++) begin
            if (lanes[i]) begin
                result[8*i +: 8] = new_word[8*i +: 8];
            end
        end
        return result;
    endfunction

    // ------------------------------------------------------------------
    // Bus decode
    // ------------------------------------------------------------------
    logic wr_ctrl;
    logic wr_status;
    logic wr_tick_div;
    logic wr_scratch;
    logic rd_event;

    assign wr_ctrl     = mmo_write && (mmo_address == ADDR_CTRL);
    assign wr_status   = mmo_write && (mmo_address == ADDR_STATUS);
    assign wr_tick_div = mmo_write && (mmo_address == ADDR_TICK_DIV);
    assign wr_scratch  = mmo_write && (mmo_address[4:3] == 2'b01);
    assign rd_event    = mmo_read  && (mmo_address == ADDR_EVENT);

    // ------------------------------------------------------------------
    // CTRL: tick_en, irq_en and the one-shot FIFO clear request
    // ------------------------------------------------------------------
    logic tick_en;
    logic irq_en;
    logic clr_pend;

    // Control bits; fifo_clr is captured for exactly one cycle.
    always_ff @(posedge clk_clk) begin
        // NOTE: every register is assigned with <= so all flops sample the
        // pre-edge values of each other, regardless of statement order.
        if (reset_reset) begin
            tick_en  <= 1'b0;
            irq_en   <= 1'b0;
            clr_pend <= 1'b0;
        end else begin
            clr_pend <= wr_ctrl && mmo_byteenable[0] && mmo_writedata[1];
            if (wr_ctrl && mmo_byteenable[0]) begin
                tick_en <= mmo_writedata[0];
                irq_en  <= mmo_writedata[2];
            end
        end
    end

    // ------------------------------------------------------------------
    // Button synchronizer and edge detection
    // ------------------------------------------------------------------
    logic [4:0] btn_meta;
    logic [4:0] btn_sync;
    logic [4:0] btn_prev;
    logic [4:0] btn_rise;
    logic [4:0] btn_fall;

    // Two-flop synchronizer followed by the copy used for edge detection.
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            btn_meta <= '0;
            btn_sync <= '0;
            btn_prev <= '0;
        end else begin
            btn_meta <= btn_in;
            btn_sync <= btn_meta;
            btn_prev <= btn_sync;
        end
    end

    assign btn_rise = btn_sync & ~btn_prev;
    assign btn_fall = ~btn_sync & btn_prev;

    // ------------------------------------------------------------------
    // Tick prescaler and tick counter
    // ------------------------------------------------------------------
    logic [31:0] tick_div;
    logic [31:0] prescale;
    logic [31:0] tick_cnt;

    // Prescaler counts 0..tick_div; each wrap advances tick_cnt.
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            tick_div <= '0;
            prescale <= '0;
            tick_cnt <= '0;
        end else if (wr_tick_div) begin
            tick_div <= merge_bytes(tick_div, mmo_writedata, mmo_byteenable);
            prescale <= '0;
        end else if (tick_en) begin
            if (prescale == tick_div) begin
                prescale <= '0;
                tick_cnt <= tick_cnt + 32'd1;
            end else begin
                prescale <= prescale + 32'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Button-event FIFO
    // ------------------------------------------------------------------
    logic [31:0]      fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             fifo_empty;
    logic             fifo_full;
    logic             push_req;
    logic             pop;
    logic             push_ok;
    logic             ovf_set;
    logic             ovf_clr;
    logic             overflow;
    logic [31:0]      event_word;
    logic [31:0]      head;

    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == CNT_FULL);
    assign push_req   = |(btn_rise | btn_fall);
    // A pending clear wins over everything else in its cycle.
    assign pop        = rd_event && !fifo_empty && !clr_pend;
    assign push_ok    = push_req && !clr_pend && (!fifo_full || pop);
    assign ovf_set    = push_req && !clr_pend && fifo_full && !pop;
    assign ovf_clr    = wr_status && mmo_byteenable[1] && mmo_writedata[10];
    assign event_word = {tick_cnt[15:0], 3'b000, btn_fall, 3'b000, btn_rise};
    assign head       = fifo_mem[rd_ptr];

    // Event storage.
    always_ff @(posedge clk_clk) begin
        // NOTE: the storage array has no reset; the pointers and count decide
        // which entries are valid, so clearing it would only cost logic.
        if (push_ok) begin
            fifo_mem[wr_ptr] <= event_word;
        end
    end

    // FIFO pointers and occupancy; power-of-two depth gives natural wrap.
    always_ff @(posedge clk_clk) begin
        if (reset_reset || clr_pend) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            if (push_ok && !pop) begin
                count <= count + CNT_ONE;
            end else if (!push_ok && pop) begin
                count <= count - CNT_ONE;
            end
        end
    end

    // Sticky overflow; a new drop in the same cycle wins over a clear.
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            overflow <= 1'b0;
        end else begin
            overflow <= (overflow && !ovf_clr) || ovf_set;
        end
    end

    // ------------------------------------------------------------------
    // Scratch registers
    // ------------------------------------------------------------------
    logic [31:0] scratch [8];

    // Eight general-purpose RW words with byte-lane writes.
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            for (int i = 0; i < 8; i++) begin
                scratch[i] <= '0;
            end
        end else if (wr_scratch) begin
            scratch[mmo_address[2:0]] <= merge_bytes(scratch[mmo_address[2:0]],
                                                     mmo_writedata, mmo_byteenable);
        end
    end

    // ------------------------------------------------------------------
    // Read path and interrupt
    // ------------------------------------------------------------------
    logic [31:0] status_word;
    logic [31:0] rd_mux;

    assign status_word = {21'd0, overflow, fifo_full, fifo_empty, 2'b00, 6'(count)};

    // Select the word at the current address from pre-write register values.
    always_comb begin
        // NOTE: rd_mux gets a default before the case so no path leaves it
        // unassigned, which would otherwise infer a latch.
        rd_mux = '0;
        case (mmo_address)
            ADDR_ID:       rd_mux = ID_VALUE;
            ADDR_CTRL:     rd_mux = {29'd0, irq_en, 1'b0, tick_en};
            ADDR_STATUS:   rd_mux = status_word;
            ADDR_EVENT:    rd_mux = fifo_empty ? 32'd0 : head;
            ADDR_TICK_DIV: rd_mux = tick_div;
            ADDR_TICK_CNT: rd_mux = tick_cnt;
            ADDR_BTN_NOW:  rd_mux = {27'd0, btn_sync};
            default: begin
                if (mmo_address[4:3] == 2'b01) begin
                    rd_mux = scratch[mmo_address[2:0]];
                end
            end
        endcase
    end

    // Registered read data (holds between reads) and registered interrupt.
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            mmo_readdata <= '0;
            irq          <= 1'b0;
        end else begin
            if (mmo_read) begin
                mmo_readdata <= rd_mux;
            end
            irq <= irq_en && !fifo_empty;
        end
    end

endmodule

// File: tb/tb_mmo_game_regs.sv
// tb_mmo_game_regs: randomized and directed bench for mmo_game_regs.
// A queue-based behavioural model predicts readdata and irq every cycle;
// directed sequences pin the model with hand-computed literal values.
module tb_mmo_game_regs;

    localparam int          DEPTH = 16;
    localparam logic [31:0] ID    = 32'h47414D45;

    logic        clk_clk        = 1'b0;
    logic        reset_reset    = 1'b1;
    logic [4:0]  mmo_address    = '0;
    logic [31:0] mmo_writedata  = '0;
    logic [3:0]  mmo_byteenable = '0;
    logic        mmo_read       = 1'b0;
    logic        mmo_write      = 1'b0;
    logic [31:0] mmo_readdata;
    logic [4:0]  btn_in         = '0;
    logic        irq;

    int n_vec  = 0;
    int n_miss = 0;

    always #5 clk_clk = ~clk_clk;

    mmo_game_regs #(
        .FIFO_DEPTH (DEPTH),
        .ID_VALUE   (ID)
    ) dut (
        .clk_clk        (clk_clk),
        .reset_reset    (reset_reset),
        .mmo_address    (mmo_address),
        .mmo_writedata  (mmo_writedata),
        .mmo_byteenable (mmo_byteenable),
        .mmo_read       (mmo_read),
        .mmo_write      (mmo_write),
        .mmo_readdata   (mmo_readdata),
        .btn_in         (btn_in),
        .irq            (irq)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model
    // ------------------------------------------------------------------
    logic [31:0] m_q[$];
    bit          m_ovf, m_tick_en, m_irq_en, m_clr;
    logic [31:0] m_div, m_presc, m_tcnt;
    logic [31:0] m_scr [8];
    logic [4:0]  m_b1, m_b2, m_b3;
    logic [31:0] exp_rd;
    bit          exp_irq;
    bit          started = 1'b0;

    function automatic logic [31:0] be_merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                             input logic [3:0] be);
        logic [31:0] r;
        r = old_w;
        for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = new_w[8*i +: 8];
        return r;
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] a);
        int n;
        n = m_q.size();
        if (a >= 5'd8 && a <= 5'd15) return m_scr[a[2:0]];
        case (a)
            5'd0:    return ID;
            5'd1:    return {29'd0, m_irq_en, 1'b0, m_tick_en};
            5'd2:    return {21'd0, m_ovf, (n == DEPTH), (n == 0), 2'b00, 6'(n)};
            5'd3:    return (n != 0) ? m_q[0] : 32'd0;
            5'd4:    return m_div;
            5'd5:    return m_tcnt;
            5'd6:    return {27'd0, m_b2};
            default: return 32'd0;
        endcase
    endfunction

    always @(posedge clk_clk) begin : model
        logic [4:0]  rise, fall;
        logic [31:0] entry;
        bit          push, pop, full_pre;
        if (reset_reset) begin
            m_q.delete();
            m_ovf = 0; m_tick_en = 0; m_irq_en = 0; m_clr = 0;
            m_div = '0; m_presc = '0; m_tcnt = '0;
            for (int i = 0; i < 8; i++) m_scr[i] = '0;
            m_b1 = '0; m_b2 = '0; m_b3 = '0;
            exp_rd = '0; exp_irq = 0;
            started = 1'b1;
        end else begin
            exp_irq = m_irq_en && (m_q.size() != 0);
            if (mmo_read) exp_rd = m_read(mmo_address);
            pop      = mmo_read && (mmo_address == 5'd3) && (m_q.size() != 0);
            rise     = m_b2 & ~m_b3;
            fall     = ~m_b2 & m_b3;
            push     = (rise | fall) != 5'd0;
            entry    = {m_tcnt[15:0], 3'b000, fall, 3'b000, rise};
            full_pre = (m_q.size() == DEPTH);
            if (mmo_write && mmo_address == 5'd2 && mmo_byteenable[1] && mmo_writedata[10])
                m_ovf = 0;
            if (m_clr) begin
                m_q.delete();
            end else begin
                if (pop) void'(m_q.pop_front());
                if (push) begin
                    if (full_pre && !pop) m_ovf = 1;
                    else m_q.push_back(entry);
                end
            end
            m_clr = mmo_write && (mmo_address == 5'd1) && mmo_byteenable[0] && mmo_writedata[1];
            if (mmo_write && mmo_address == 5'd4) begin
                m_div   = be_merge(m_div, mmo_writedata, mmo_byteenable);
                m_presc = '0;
            end else if (m_tick_en) begin
                if (m_presc == m_div) begin
                    m_presc = '0;
                    m_tcnt  = m_tcnt + 32'd1;
                end else begin
                    m_presc = m_presc + 32'd1;
                end
            end
            if (mmo_write && mmo_address == 5'd1 && mmo_byteenable[0]) begin
                m_tick_en = mmo_writedata[0];
                m_irq_en  = mmo_writedata[2];
            end
            if (mmo_write && mmo_address >= 5'd8 && mmo_address <= 5'd15)
                m_scr[mmo_address[2:0]] = be_merge(m_scr[mmo_address[2:0]], mmo_writedata,
                                                   mmo_byteenable);
            m_b3 = m_b2;
            m_b2 = m_b1;
            m_b1 = btn_in;
        end
    end

    // Every-cycle comparison of DUT outputs against the model.
    always @(negedge clk_clk) begin
        if (started) begin
            check("readdata", mmo_readdata, exp_rd);
            check("irq", {31'd0, irq}, {31'd0, exp_irq});
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers (all called at a negedge, return at a negedge)
    // ------------------------------------------------------------------
    task automatic bus(input bit rd, input bit wr, input logic [4:0] a, input logic [31:0] d,
                       input logic [3:0] be, output logic [31:0] q);
        mmo_read = rd; mmo_write = wr; mmo_address = a;
        mmo_writedata = d; mmo_byteenable = be;
        @(posedge clk_clk);
        @(negedge clk_clk);
        q = mmo_readdata;
        mmo_read = 1'b0; mmo_write = 1'b0;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d, input logic [3:0] be);
        logic [31:0] q;
        bus(1'b0, 1'b1, a, d, be, q);
    endtask

    task automatic rd(input logic [4:0] a, output logic [31:0] q);
        bus(1'b1, 1'b0, a, 32'd0, 4'h0, q);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk_clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish within the time limit");
        $fatal(1);
    end

    initial begin
        logic [31:0] q;
        logic [31:0] d;
        logic [4:0]  a;
        int          r;

        reset_reset = 1'b1;
        idle(3);
        reset_reset = 1'b0;

        // Reset state and ID latency.
        rd(5'd0, q);  check("id_read", q, ID);
        rd(5'd7, q);  check("addr7_read", q, 32'd0);
        rd(5'd1, q);  check("ctrl_reset", q, 32'd0);
        rd(5'd2, q);  check("status_reset", q, 32'h0000_0100);
        rd(5'd4, q);  check("tick_div_reset", q, 32'd0);

        // Byte-lane writes and read-during-write.
        wr(5'd11, 32'hFFFF_FFFF, 4'hF);
        wr(5'd11, 32'h1234_5678, 4'b0101);
        rd(5'd11, q); check("scratch3_lanes", q, 32'hFF34_FF78);
        bus(1'b1, 1'b1, 5'd11, 32'hAAAA_AAAA, 4'hF, q);
        check("rw_same_cycle_old", q, 32'hFF34_FF78);
        rd(5'd11, q); check("rw_same_cycle_new", q, 32'hAAAA_AAAA);

        // Prescaler: TICK_DIV=3 over 40 enabled cycles, then frozen.
        wr(5'd4, 32'd3, 4'hF);
        wr(5'd1, 32'd1, 4'h1);
        idle(40);
        wr(5'd1, 32'd0, 4'h1);
        rd(5'd5, q);
        n_vec++;
        if (q < 32'd9 || q > 32'd11) begin
            n_miss++;
            $display("FAIL tick_cnt_run: got %0d, expected 10 +/- 1", q);
        end
        idle(10);
        rd(5'd5, q);
        n_vec++;
        if (q < 32'd9 || q > 32'd11) begin
            n_miss++;
            $display("FAIL tick_cnt_frozen: got %0d, expected 10 +/- 1", q);
        end

        // Button bit2 press and release with irq enabled.
        wr(5'd1, 32'd4, 4'h1);
        btn_in = 5'b00100; idle(6);
        btn_in = 5'b00000; idle(6);
        check("irq_after_events", {31'd0, irq}, 32'd1);
        rd(5'd2, q);  check("status_count2", {26'd0, q[5:0]}, 32'd2);
        rd(5'd3, q);  check("event_rise2", {16'd0, q[15:0]}, 32'h0000_0004);
        rd(5'd3, q);  check("event_fall2", {16'd0, q[15:0]}, 32'h0000_0400);
        idle(2);
        check("irq_after_pops", {31'd0, irq}, 32'd0);
        rd(5'd3, q);  check("event_empty", q, 32'd0);

        // 17 events into a 16-deep FIFO, then clear overflow.
        wr(5'd1, 32'd6, 4'h1);
        for (int i = 0; i < 17; i++) begin
            btn_in[0] = ~btn_in[0];
            idle(2);
        end
        idle(4);
        rd(5'd2, q);  check("status_full_ovf", q, 32'h0000_0610);
        wr(5'd2, 32'h0000_0400, 4'b0010);
        rd(5'd2, q);  check("status_ovf_cleared", q, 32'h0000_0210);

        // Full FIFO: edge and pop land in the same cycle.
        btn_in[1] = 1'b1;
        idle(2);
        rd(5'd3, q);  check("pop_head_first", {16'd0, q[15:0]}, 32'h0000_0001);
        idle(4);
        rd(5'd2, q);  check("status_push_pop_full", q, 32'h0000_0210);

        // Reset in the middle of an event burst with a bus access in flight.
        wr(5'd1, 32'd5, 4'h1);
        for (int i = 0; i < 6; i++) begin
            btn_in = 5'($urandom);
            idle(1);
        end
        reset_reset = 1'b1; btn_in = '0;
        mmo_read = 1'b1; mmo_write = 1'b1; mmo_address = 5'd8;
        mmo_writedata = 32'hDEAD_BEEF; mmo_byteenable = 4'hF;
        idle(2);
        mmo_read = 1'b0; mmo_write = 1'b0;
        reset_reset = 1'b0;
        idle(1);
        for (int i = 0; i < 16; i++) begin
            rd(5'(i), q);
            check($sformatf("reset_value_addr%0d", i), q,
                  (i == 0) ? ID : ((i == 2) ? 32'h0000_0100 : 32'd0));
        end

        // Randomized traffic; the model checks every cycle.
        for (int c = 0; c < 2000; c++) begin
            reset_reset = ($urandom_range(0, 199) == 0);
            r = $urandom_range(0, 9);
            if (r < 3)       a = 5'd3;
            else if (r < 5)  a = 5'd2;
            else if (r == 5) a = 5'd1;
            else if (r == 6) a = 5'd4;
            else if (r == 7) a = 5'd5;
            else if (r == 8) a = 5'($urandom_range(8, 15));
            else             a = 5'($urandom_range(0, 31));
            d = $urandom;
            if (a == 5'd4) d = $urandom_range(0, 5);
            if (a == 5'd1 && $urandom_range(0, 7) != 0) d[1] = 1'b0;
            mmo_address    = a;
            mmo_writedata  = d;
            mmo_byteenable = 4'($urandom_range(0, 15));
            mmo_read       = ($urandom_range(0, 2) == 0);
            mmo_write      = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 3) == 0)
                btn_in = btn_in ^ (5'd1 << $urandom_range(0, 4));
            idle(1);
        end
        reset_reset = 1'b0;
        mmo_read = 1'b0; mmo_write = 1'b0;
        idle(4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
